// File: rtl/apb_master_bridge_if.sv
// Bundle of the command/response handshake and APB bus signals around apb_master_bridge.
// The master modport is the bridge's view; the slave modport is its environment's view.
interface apb_master_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // Command accepted on any PCLK edge with cmd_valid & cmd_ready; the command fields must
   // be held stable while cmd_valid is high and not yet accepted. rsp_valid is a one-cycle
   // pulse with no backpressure.
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   logic                  busy;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
             PADDR, PSEL, PENABLE, PWRITE, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
             PADDR, PSEL, PENABLE, PWRITE, PWDATA
   );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: valid/ready command in, APB SETUP/ACCESS out, one-cycle response.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                PCLK,
   input  logic                PRESETn,
   apb_master_bridge_if.master bus,
   output logic [1:0]          state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t state;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] wait_cnt;
`endif

   assign bus.cmd_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign state_dbg     = state;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state         <= IDLE;
         bus.PSEL      <= 1'b0;
         bus.PENABLE   <= 1'b0;
         bus.PWRITE    <= 1'b0;
         bus.PADDR     <= '0;
         bus.PWDATA    <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
         wait_cnt      <= '0;
`endif
      end else begin
         bus.rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  bus.PADDR   <= bus.cmd_addr;
                  bus.PWDATA  <= bus.cmd_wdata;
                  bus.PWRITE  <= bus.cmd_write;
                  bus.PSEL    <= 1'b1;
                  bus.PENABLE <= 1'b0;
                  state       <= SETUP;
               end
            end
            SETUP: begin
               bus.PENABLE <= 1'b1;
               state       <= ACCESS;
`ifdef APB_TIMEOUT_EN
               wait_cnt    <= '0;
`endif
            end
            ACCESS: begin
               // A ready slave wins over a timeout landing on the same edge.
               if (bus.PREADY) begin
                  bus.PSEL      <= 1'b0;
                  bus.PENABLE   <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= bus.PSLVERR;
                  bus.rsp_rdata <= bus.PWRITE ? '0 : bus.PRDATA;
                  state         <= IDLE;
               end
`ifdef APB_TIMEOUT_EN
               else if (wait_cnt == CNT_LAST) begin
                  bus.PSEL      <= 1'b0;
                  bus.PENABLE   <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_rdata <= '0;
                  state         <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
`endif
            end
            default: begin
               bus.PSEL    <= 1'b0;
               bus.PENABLE <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: command driver, reactive APB slave,
// response monitor with an expected-response queue.
module tb_apb_master_bridge;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;
   // {pwdata, psel_cycles, penable_cycles, pwrite, paddr, rsp_err, rsp_rdata}
   localparam int W  = DW + 8 + 8 + 1 + AW + 1 + DW;

   logic       PCLK = 1'b0;
   logic       PRESETn;
   logic [1:0] state_dbg;
   int         cyc = 0;

   apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .PCLK     (PCLK),
      .PRESETn  (PRESETn),
      .bus      (bus),
      .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 PCLK = ~PCLK;
   initial forever begin
      @(posedge PCLK);
      cyc++;
   end

   int            n_checks = 0;
   int            n_errors = 0;
   int            rsp_cnt  = 0;
   int            exp_rsps = 0;
   logic [W-1:0]  exp_q[$];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] pack(input logic [DW-1:0] pwdata, input logic [7:0] psel_c,
                                         input logic [7:0] pen_c, input logic pwrite,
                                         input logic [AW-1:0] paddr, input logic err,
                                         input logic [DW-1:0] rdata);
      return {pwdata, psel_c, pen_c, pwrite, paddr, err, rdata};
   endfunction

   // reactive APB slave
   int            cfg_waits = 0;
   logic [DW-1:0] cfg_rdata = '0;
   logic          cfg_err   = 1'b0;
   logic          stuck     = 1'b0;
   int            wait_left = 0;

   initial begin
      bus.PREADY  = 1'b0;
      bus.PRDATA  = '0;
      bus.PSLVERR = 1'b0;
      forever begin
         @(negedge PCLK);
         if (bus.PSEL && bus.PENABLE && !stuck) begin
            if (wait_left > 0) begin
               bus.PREADY = 1'b0;
               wait_left--;
            end else begin
               bus.PREADY  = 1'b1;
               bus.PRDATA  = cfg_rdata;
               bus.PSLVERR = cfg_err;
            end
         end else begin
            bus.PREADY  = 1'b0;
            bus.PSLVERR = 1'b0;
            bus.PRDATA  = '0;
            wait_left   = cfg_waits;
         end
      end
   end

   // response monitor / scoreboard
   initial begin
      logic [7:0]    psel_c;
      logic [7:0]    pen_c;
      logic          stable_bad;
      logic [AW-1:0] cap_addr;
      logic          cap_wr;
      logic [DW-1:0] cap_wd;
      logic [W-1:0]  exp_w;
      psel_c = '0; pen_c = '0; stable_bad = 1'b0;
      cap_addr = '0; cap_wr = 1'b0; cap_wd = '0;
      forever begin
         @(negedge PCLK);
         if (!PRESETn) begin
            psel_c = '0; pen_c = '0; stable_bad = 1'b0;
         end else begin
            if (bus.PSEL && !bus.PENABLE) begin
               cap_addr = bus.PADDR; cap_wr = bus.PWRITE; cap_wd = bus.PWDATA;
            end
            if (bus.PSEL && bus.PENABLE &&
                (bus.PADDR !== cap_addr || bus.PWRITE !== cap_wr || bus.PWDATA !== cap_wd))
               stable_bad = 1'b1;
            if (bus.PSEL)    psel_c++;
            if (bus.PENABLE) pen_c++;
            if (bus.rsp_valid) begin
               rsp_cnt++;
               if (exp_q.size() == 0) begin
                  check("unexpected_rsp", 1, 0);
               end else begin
                  exp_w = exp_q.pop_front();
                  check("rsp", pack(bus.PWDATA, psel_c, pen_c, bus.PWRITE, bus.PADDR,
                                    bus.rsp_err, bus.rsp_rdata), exp_w);
                  check("access_stable", stable_bad, 0);
               end
               psel_c = '0; pen_c = '0; stable_bad = 1'b0;
            end
         end
      end
   end

   // driver tasks (called at a negedge, return at a negedge)
   task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic push, output int acc_cyc);
      int n;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
      n = 0;
      while (!bus.cmd_ready && n < 50) begin
         @(negedge PCLK);
         n++;
      end
      acc_cyc = cyc;
      if (!bus.cmd_ready) begin
         check("accept_timeout", 0, 1);
      end else begin
         if (push) begin
            exp_rsps++;
            if (stuck)
               exp_q.push_back(pack(d, 8'(TO + 1), 8'(TO), wr, a, 1'b1, '0));
            else
               exp_q.push_back(pack(d, 8'(cfg_waits + 2), 8'(cfg_waits + 1), wr, a, cfg_err,
                                    wr ? '0 : cfg_rdata));
         end
         @(posedge PCLK);
         @(negedge PCLK);
      end
   endtask

   task automatic drop_cmd();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
         @(negedge PCLK);
         n++;
      end
      check("wait_done", (exp_q.size() == 0 && !bus.busy), 1);
   endtask

   task automatic slave_cfg(input int waits, input logic [DW-1:0] rd, input logic err);
      cfg_waits = waits;
      cfg_rdata = rd;
      cfg_err   = err;
   endtask

   initial begin
      int a0, a1, a2, n;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      PRESETn = 1'b0;
      repeat (3) @(negedge PCLK);
      check("rst_psel", bus.PSEL, 0);
      check("rst_penable", bus.PENABLE, 0);
      check("rst_pwrite", bus.PWRITE, 0);
      check("rst_paddr", bus.PADDR, 0);
      check("rst_pwdata", bus.PWDATA, 0);
      check("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 0);
      check("rst_ready_busy", {bus.cmd_ready, bus.busy}, 2'b10);
      check("rst_state", state_dbg, 0);
      PRESETn = 1'b1;
      @(negedge PCLK);

      // write then read, zero wait states
      slave_cfg(0, 32'h1111_2222, 1'b0);
      send_cmd(1'b1, 32'h0000_0000, 32'h1111_2222, 1'b1, a0);
      drop_cmd();
      wait_done(20);
      send_cmd(1'b0, 32'h0000_0000, 32'h0, 1'b1, a0);
      drop_cmd();
      wait_done(20);

      // read with three wait states
      slave_cfg(3, 32'h5555_6666, 1'b0);
      send_cmd(1'b0, 32'h0000_0008, 32'h0, 1'b1, a0);
      drop_cmd();
      wait_done(20);

      // slave error on read
      slave_cfg(0, 32'hDEAD_0000, 1'b1);
      send_cmd(1'b0, 32'h0000_000C, 32'h0, 1'b1, a0);
      drop_cmd();
      wait_done(20);

      // back-to-back writes with cmd_valid held
      slave_cfg(0, 32'h0, 1'b0);
      send_cmd(1'b1, 32'h0, 32'hA000_0000, 1'b1, a0);
      send_cmd(1'b1, 32'h4, 32'hA000_0004, 1'b1, a1);
      send_cmd(1'b1, 32'h8, 32'hA000_0008, 1'b1, a2);
      drop_cmd();
      wait_done(30);
      check("b2b_gap1", a1 - a0, 3);
      check("b2b_gap2", a2 - a1, 3);

      // random transfers
      for (int i = 0; i < 8; i++) begin
         slave_cfg($urandom_range(0, 4), $urandom, 1'($urandom_range(0, 1)));
         send_cmd(1'($urandom_range(0, 1)), {$urandom_range(0, 255), 2'b00}, $urandom, 1'b1, a0);
         drop_cmd();
         wait_done(30);
      end

      // reset during ACCESS with the slave stalled
      stuck = 1'b1;
      send_cmd(1'b0, 32'h0000_0020, 32'h0, 1'b0, a0);
      drop_cmd();
      n = 0;
      while (!(bus.PSEL && bus.PENABLE) && n < 10) begin
         @(negedge PCLK);
         n++;
      end
      check("reached_access", {bus.PSEL, bus.PENABLE}, 2'b11);
      @(negedge PCLK);
      #2 PRESETn = 1'b0;
      #1;
      check("async_drop", {bus.PSEL, bus.PENABLE}, 2'b00);
      @(negedge PCLK);
      @(negedge PCLK);
      PRESETn = 1'b1;
      stuck = 1'b0;
      check("ready_after_rst", {bus.cmd_ready, bus.busy}, 2'b10);
      repeat (4) @(negedge PCLK);

      // stalled slave: timeout or indefinite wait
      stuck = 1'b1;
`ifdef APB_TIMEOUT_EN
      send_cmd(1'b0, 32'h0000_0010, 32'h0, 1'b1, a0);
      drop_cmd();
      wait_done(60);
      stuck = 1'b0;
`else
      send_cmd(1'b0, 32'h0000_0010, 32'h0, 1'b0, a0);
      drop_cmd();
      repeat (100) @(negedge PCLK);
      check("still_busy", bus.busy, 1);
      #2 PRESETn = 1'b0;
      @(negedge PCLK);
      @(negedge PCLK);
      PRESETn = 1'b1;
      stuck = 1'b0;
      check("recover_idle", bus.cmd_ready, 1);
`endif
      repeat (3) @(negedge PCLK);
      check("rsp_count", rsp_cnt, exp_rsps);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
      $fatal(1, "bench timeout");
   end
endmodule
